pipe_alu4: RTL and testbench

//  Four-stage pipelined register-to-register ALU with a writeback memory.
//  - Each cycle it reads two operands from a 16x16 register bank and applies one of 12 ALU ops.
//  - The result is written back to the register bank and then stored to a 256x16 data memory.
//  - Teaching/datapath block: a free-running pipeline with no stalls, no forwarding and no handshake.

---
 rtl/pipe_alu4_pkg.sv | 22 ++
 rtl/pipe_alu4_if.sv | 15 +
 rtl/pipe_alu4_alu.sv | 30 +++
 rtl/pipe_alu4.sv | 104 ++++++++++
 tb/tb_pipe_alu4.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_alu4_pkg.sv
// Shared widths and opcode encodings for the pipe_alu4 datapath and its ALU.
package pipe_alu_pkg;

    localparam int DW = 16;
    localparam int RA = 4;
    localparam int MA = 8;
    localparam int FW = 4;

    localparam logic [FW-1:0] OP_ADD  = 4'd0;
    localparam logic [FW-1:0] OP_SUB  = 4'd1;
    localparam logic [FW-1:0] OP_MUL  = 4'd2;
    localparam logic [FW-1:0] OP_PASA = 4'd3;
    localparam logic [FW-1:0] OP_PASB = 4'd4;
    localparam logic [FW-1:0] OP_AND  = 4'd5;
    localparam logic [FW-1:0] OP_OR   = 4'd6;
    localparam logic [FW-1:0] OP_XOR  = 4'd7;
    localparam logic [FW-1:0] OP_NOTA = 4'd8;
    localparam logic [FW-1:0] OP_NOTB = 4'd9;
    localparam logic [FW-1:0] OP_SHR  = 4'd10;
    localparam logic [FW-1:0] OP_SHL  = 4'd11;

endpackage

// File: rtl/pipe_alu4_if.sv
// Instruction fields into the pipeline and the stage-3 result coming back out.
interface pipe_alu4_if;
    import pipe_alu_pkg::*;

    logic [RA-1:0] rs1;
    logic [RA-1:0] rs2;
    logic [RA-1:0] rd;
    logic [FW-1:0] func;
    logic [MA-1:0] addr;
    logic [DW-1:0] Zout;

    modport master (output rs1, rs2, rd, func, addr, input Zout);
    modport slave  (input rs1, rs2, rd, func, addr, output Zout);

endinterface

// File: rtl/pipe_alu4_alu.sv
// Combinational 16-bit ALU; every result is truncated to the data width.
module alu16
    import pipe_alu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [FW-1:0] func,
    output logic [DW-1:0] z
);

    always_comb begin
        z = '0;
        case (func)
            OP_ADD:  z = a + b;
            OP_SUB:  z = a - b;
            OP_MUL:  z = a * b;
            OP_PASA: z = a;
            OP_PASB: z = b;
            OP_AND:  z = a & b;
            OP_OR:   z = a | b;
            OP_XOR:  z = a ^ b;
            OP_NOTA: z = ~a;
            OP_NOTB: z = ~b;
            OP_SHR:  z = a >> 1;
            OP_SHL:  z = a << 1;
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/pipe_alu4.sv
// Four-stage register-to-register ALU pipeline: read, execute, regbank writeback,
// memory store. Free-running, no stalls or forwarding.
module pipe_alu4
    import pipe_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    pipe_alu4_if.slave  bus
);

    logic [DW-1:0] regbank [0:(1<<RA)-1];
    logic [DW-1:0] mem     [0:(1<<MA)-1];

    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [RA-1:0] rd1_q, rd1_d;
    logic [FW-1:0] func1_q, func1_d;
    logic [MA-1:0] addr1_q, addr1_d;
    logic          v1_q, v1_d;

    logic [DW-1:0] z_q, z_d;
    logic [RA-1:0] rd2_q, rd2_d;
    logic [MA-1:0] addr2_q, addr2_d;
    logic          v2_q, v2_d;

    logic [DW-1:0] zout_q, zout_d;
    logic [MA-1:0] addr3_q, addr3_d;
    logic          v3_q, v3_d;

    logic [DW-1:0] alu_z;

    alu16 u_alu (
        .a    (a_q),
        .b    (b_q),
        .func (func1_q),
        .z    (alu_z)
    );

    always_comb begin
        a_d     = regbank[bus.rs1];
        b_d     = regbank[bus.rs2];
        rd1_d   = bus.rd;
        func1_d = bus.func;
        addr1_d = bus.addr;
        v1_d    = 1'b1;

        z_d     = alu_z;
        rd2_d   = rd1_q;
        addr2_d = addr1_q;
        v2_d    = v1_q;

        zout_d  = z_q;
        addr3_d = addr2_q;
        v3_d    = v2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            rd1_q   <= '0;
            func1_q <= '0;
            addr1_q <= '0;
            v1_q    <= 1'b0;
            z_q     <= '0;
            rd2_q   <= '0;
            addr2_q <= '0;
            v2_q    <= 1'b0;
            zout_q  <= '0;
            addr3_q <= '0;
            v3_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            rd1_q   <= rd1_d;
            func1_q <= func1_d;
            addr1_q <= addr1_d;
            v1_q    <= v1_d;
            z_q     <= z_d;
            rd2_q   <= rd2_d;
            addr2_q <= addr2_d;
            v2_q    <= v2_d;
            zout_q  <= zout_d;
            addr3_q <= addr3_d;
            v3_q    <= v3_d;
        end
    end

    // Storage keeps its contents across reset; a reset edge squashes any write
    // still pending in S3/S4 so in-flight instructions leave no trace.
    always_ff @(posedge clk) begin
        if (!rst && v2_q) begin
            regbank[rd2_q] <= z_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && v3_q) begin
            mem[addr3_q] <= zout_q;
        end
    end

    assign bus.Zout = zout_q;

endmodule

// File: tb/tb_pipe_alu4.sv
// Directed bench for pipe_alu4: scoreboard of expected Zout/regbank/mem effects,
// each checked on the cycle the pipeline should produce it.
module tb_pipe_alu4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_alu4_if bus ();

    pipe_alu4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        int          kind;   // 0 Zout, 1 regbank, 2 mem
        int          idx;
        logic [15:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mreg [0:15];
    logic [15:0] mmem [0:255];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a + b);
            4'd1:    return 16'(a - b);
            4'd2:    return 16'(a * b);
            4'd3:    return a;
            4'd4:    return b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ~a;
            4'd9:    return ~b;
            4'd10:   return a >> 1;
            4'd11:   return 16'(a << 1);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_entry(input exp_t e);
        logic [15:0] obs;
        case (e.kind)
            0:       obs = bus.Zout;
            1:       begin obs = dut.regbank[e.idx]; mreg[e.idx] = e.val; end
            default: begin obs = dut.mem[e.idx];     mmem[e.idx] = e.val; end
        endcase
        compare(e.tag, obs, e.val);
    endtask

    task automatic step();
        exp_t keep[$];
        @(posedge clk);
        #1;
        cyc++;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) check_entry(sb[i]);
            else                  keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic [3:0] f, input logic [7:0] addr, input string name);
        logic [15:0] z;
        int          n;
        exp_t        e;
        bus.rs1  = rs1;
        bus.rs2  = rs2;
        bus.rd   = rd;
        bus.func = f;
        bus.addr = addr;
        z = alu_ref(mreg[rs1], mreg[rs2], f);
        n = cyc + 1;
        e = '{due: n + 2, kind: 0, idx: 0,        val: z, tag: {name, "_zout"}}; sb.push_back(e);
        e = '{due: n + 2, kind: 1, idx: int'(rd), val: z, tag: {name, "_reg"}};  sb.push_back(e);
        e = '{due: n + 3, kind: 2, idx: int'(addr), val: z, tag: {name, "_mem"}}; sb.push_back(e);
        $display("cyc %0d issue %s rs1=%0d rs2=%0d rd=%0d func=%0d addr=%0d exp=%h",
                 n, name, rs1, rs2, rd, f, addr, z);
        step();
    endtask

    // A reset edge squashes everything in flight: pending targets must still hold old values.
    task automatic reset_cycle(input string name);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        compare({name, "_zout"}, bus.Zout, 16'h0000);
        foreach (sb[i]) begin
            if (sb[i].kind == 1)
                compare({sb[i].tag, "_squashed"}, dut.regbank[sb[i].idx], mreg[sb[i].idx]);
            else if (sb[i].kind == 2)
                compare({sb[i].tag, "_squashed"}, dut.mem[sb[i].idx], mmem[sb[i].idx]);
        end
        sb.delete();
        $display("cyc %0d reset %s Zout=%h", cyc, name, bus.Zout);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rs1  = 4'd0;
        bus.rs2  = 4'd0;
        bus.rd   = 4'd0;
        bus.func = 4'd0;
        bus.addr = 8'd0;
        for (int k = 0; k < 16; k++) begin
            mreg[k] = 16'(k);
            dut.regbank[k] <= 16'(k);
        end
        for (int k = 0; k < 256; k++) begin
            mmem[k] = 16'hC000 | 16'(k);
            dut.mem[k] <= 16'hC000 | 16'(k);
        end

        // Power-on reset held two cycles: Zout clear, no spurious r0/mem[0] write
        reset_cycle("rst0");
        reset_cycle("rst1");
        compare("idle_r0", dut.regbank[0], mreg[0]);
        compare("idle_mem0", dut.mem[0], mmem[0]);
        rst = 1'b0;

        // Back-to-back instruction stream
        issue(4'd10, 4'd5, 4'd10, 4'd5,  8'd125, "i1");
        issue(4'd12, 4'd8, 4'd12, 4'd5,  8'd126, "i2");
        issue(4'd13, 4'd5, 4'd14, 4'd0,  8'd128, "i3");
        issue(4'd7,  4'd3, 4'd13, 4'd11, 8'd127, "i4");
        issue(4'd9,  4'd5, 4'd15, 4'd1,  8'd129, "i5");

        // Every opcode with A=r3, B=r5, plus a wrapping subtract
        for (int f = 0; f < 16; f++)
            issue(4'd3, 4'd5, 4'd6, 4'(f), 8'(32 + f), $sformatf("op%0d", f));
        issue(4'd2, 4'd5, 4'd6, 4'd1, 8'd60, "sub_wrap");

        // RAW hazard: the next instruction sees the old r1, the one 3 later sees the new one
        issue(4'd2,  4'd3, 4'd1,  4'd0, 8'd70,  "raw_prod");
        issue(4'd1,  4'd0, 4'd7,  4'd3, 8'd71,  "raw_early");
        issue(4'd15, 4'd0, 4'd15, 4'd3, 8'd200, "fill_a");
        issue(4'd1,  4'd0, 4'd8,  4'd3, 8'd72,  "raw_late");

        // Reset with three instructions in flight
        issue(4'd3, 4'd5, 4'd4, 4'd0, 8'd150, "fl_x");
        issue(4'd5, 4'd5, 4'd9, 4'd2, 8'd151, "fl_y");
        issue(4'd3, 4'd3, 4'd2, 4'd0, 8'd152, "fl_z");
        bus.rs1  = 4'd3;
        bus.rs2  = 4'd5;
        bus.rd   = 4'd0;
        bus.func = 4'd0;
        bus.addr = 8'd0;
        reset_cycle("mid_rst0");
        reset_cycle("mid_rst1");
        compare("mid_idle_r0", dut.regbank[0], mreg[0]);
        compare("mid_idle_mem0", dut.mem[0], mmem[0]);
        rst = 1'b0;

        // Refill after reset, with another RAW pair
        issue(4'd3,  4'd5, 4'd11, 4'd0, 8'd160, "post_a");
        issue(4'd11, 4'd0, 4'd12, 4'd3, 8'd161, "post_old");
        issue(4'd15, 4'd0, 4'd15, 4'd3, 8'd200, "fill_b");
        issue(4'd11, 4'd0, 4'd12, 4'd3, 8'd162, "post_new");
        for (int k = 0; k < 3; k++)
            issue(4'd0, 4'd0, 4'd0, 4'd3, 8'd0, $sformatf("drain%0d", k));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
